score_keeper: RTL and testbench
===============================

# score_keeper

Producer of the 16-bit `score` consumed by the score bar renderer, plus combo and multiplier state for the HUD. It collects per-lane hit judgements from the arrow judges and buffers simultaneous events in a per-lane pending register. It retires one event per clock through a fixed-priority serializer and accumulates points with a combo-driven multiplier and saturating arithmetic. A small play-state machine gates scoring to the active song.

## Interface
- `NUM_LANES`, 4: number of arrow lanes.
- `PERFECT_PTS`, 16'd512: base points for grade 2'b11.
- `GREAT_PTS`, 16'd256: base points for grade 2'b10.
- `GOOD_PTS`, 16'd128: base points for grade 2'b01. A miss (2'b00) scores 0.
- `COMBO_STEP`, 10: consecutive non-miss hits per multiplier increment.
- `MAX_MULT`, 4: multiplier ceiling, range 1..7.

- `Clk` in 1: system clock. One clock only.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse that begins a song.
- `song_end` in 1: one-cycle pulse marking the end of the chart.
- `lane_hit` in NUM_LANES: one-cycle event strobe per lane.
- `lane_grade` in 2*NUM_LANES: grade for lane i is at bits [2i+1:2i]. Valid only with `lane_hit[i]`.
- `score` out 16: accumulated score.
- `combo` out 10: current consecutive non-miss count.
- `max_combo` out 10: best combo this song.
- `multiplier` out 3: current multiplier, 1..MAX_MULT.
- `busy` out 1: high while any pending bit is set.
- `overflow` out 1: sticky; a hit was dropped.
- `done` out 1: high in state DONE.

## Operation
- **States:** IDLE, PLAY, DRAIN, DONE. Reset enters IDLE.
- **IDLE → PLAY on `start`:**
  - Clears `score`, `combo`, `max_combo`, `overflow`, and pending bits.
  - Sets `multiplier` to 1 and the step counter to 0.
- **PLAY → DRAIN on `song_end`.** In DRAIN, new `lane_hit` are ignored; pending events still retire.
- **DRAIN → DONE** when pending is empty. This includes the same cycle the last event retires.
- **DONE → PLAY on `start`**, with the same clears as IDLE → PLAY.
- **`start` while in PLAY or DRAIN:** restarts PLAY with the same clears. Pending events are discarded.
- **Capture (PLAY only):**
  - `lane_hit[i]` sets `pend[i]` and stores the grade in `gr[i]`.
  - If `pend[i]` is already set and is not being retired this cycle, the new event is dropped and `overflow` is set.
  - If `pend[i]` is being retired in the same cycle, the new event is accepted with no overflow.
- **Retire:** each cycle, the lowest-index set `pend[i]` is cleared and its grade is applied.
- **Non-miss grade:**
  - Add = base × `multiplier`, computed at 19 bits.
  - `score` = min(`score` + add, 16'hFFFF).
  - `combo` increments, saturating at 1023.
  - `max_combo` = max(`max_combo`, new `combo`), updated on the same edge.
  - The step counter increments. On reaching COMBO_STEP it wraps to 0, and `multiplier` increments if below MAX_MULT.
  - The multiplier used for the add is the value before this event's update.
- **Miss grade:** `combo` = 0, step counter = 0, `multiplier` = 1, `score` unchanged.
- **Other status:** `busy` = OR of pending bits. `done` = (state == DONE).

## Timing
- **Reset values:** `score` 0, `combo` 0, `max_combo` 0, `multiplier` 1, `busy` 0, `overflow` 0, `done` 0, state IDLE.
- **Latency:**
  - A hit sampled at edge N sets pending at edge N.
  - The earliest retirement is at edge N+1, and `score` is visible after edge N+1.
- **Worst-case drain:** k simultaneous hits retire over k consecutive cycles, in order lane 0 first.
- **All outputs are registered.** `score` changes at most once per cycle.
- **Reset asserted mid-song** returns everything to reset values immediately, with no pending retirement.

## Test plan
- **Single hit:** reset, `start`, one lane-0 perfect → `score` = 512, `combo` = 1, `multiplier` = 1, `busy` high for 1 cycle.
- **Multiplier step:** 11 sequential lane-1 perfects →
  - after the 10th: `score` = 5120, `multiplier` = 2;
  - after the 11th: `score` = 6144, `combo` = 11.
- **Miss resets combo:** 11 perfects, then a miss, then a good →
  - `combo` = 1, `max_combo` = 11, `multiplier` = 1;
  - `score` = 6144 + 128 = 6272.
- **Simultaneous lanes:** all 4 lanes great in one cycle →
  - retire over 4 cycles in lane order 0, 1, 2, 3;
  - `score` steps 256/512/768/1024, `busy` high for exactly 4 cycles.
- **Overflow and retire-cycle re-hit:**
  - Lanes 0–3 hit at cycle N, lane 3 hits again at N+1 → `overflow` = 1, final `score` counts 4 events.
  - Lane 0 re-hit on its retire cycle → accepted, no overflow.
- **Saturation, end of song, and reset:**
  - Drive perfects at `multiplier` 4 until `score` ≥ 63488; the next perfect → `score` = 65535.
  - `song_end` with 2 events pending → `done` rises the cycle after the last retires.
  - Asserting `reset` mid-song → all outputs return to reset values immediately.

Source files
------------

// File: rtl/score_keeper.sv
// Score accumulator for the rhythm game: per-lane hit capture, lowest-lane-first
// retirement, combo-driven multiplier and saturating 16-bit score.
module score_keeper #(
  parameter int unsigned NUM_LANES   = 4,
  parameter logic [15:0] PERFECT_PTS = 16'd512,
  parameter logic [15:0] GREAT_PTS   = 16'd256,
  parameter logic [15:0] GOOD_PTS    = 16'd128,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   song_end,
  input  logic [NUM_LANES-1:0]   lane_hit,
  input  logic [2*NUM_LANES-1:0] lane_grade,
  output logic [15:0]            score,
  output logic [9:0]             combo,
  output logic [9:0]             max_combo,
  output logic [2:0]             multiplier,
  output logic                   busy,
  output logic                   overflow,
  output logic                   done
);

  localparam int unsigned StepW = $clog2(COMBO_STEP + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [NUM_LANES-1:0]   pend_q, pend_d;
  logic [2*NUM_LANES-1:0] gr_q, gr_d;
  logic [15:0]            score_q, score_d;
  logic [9:0]             combo_q, combo_d;
  logic [9:0]             max_combo_q, max_combo_d;
  logic [2:0]             mult_q, mult_d;
  logic [StepW-1:0]       step_q, step_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_LANES-1:0]   ret_oh;
  logic [1:0]             ret_grade;
  logic [15:0]            base;
  logic [18:0]            add;
  logic [18:0]            sum;

  // Isolate the lowest set pending bit; that lane retires this cycle.
  assign ret_oh = pend_q & (~pend_q + 1'b1);

  always_comb begin
    ret_grade = 2'b00;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) ret_grade = gr_q[2*i +: 2];
    end
  end

  always_comb begin
    case (ret_grade)
      2'b11:   base = PERFECT_PTS;
      2'b10:   base = GREAT_PTS;
      2'b01:   base = GOOD_PTS;
      default: base = 16'd0;
    endcase
    add = 19'(base) * 19'(mult_q);
    sum = 19'(score_q) + add;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    gr_d        = gr_q;
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    mult_d      = mult_q;
    step_d      = step_q;
    overflow_d  = overflow_q;

    if (start) begin
      // Start from any state restarts the song and discards pending events.
      state_d     = StPlay;
      pend_d      = '0;
      score_d     = '0;
      combo_d     = '0;
      max_combo_d = '0;
      mult_d      = 3'd1;
      step_d      = '0;
      overflow_d  = 1'b0;
    end else begin
      if (|pend_q) begin
        pend_d = pend_q & ~ret_oh;
        if (ret_grade != 2'b00) begin
          score_d = (sum > 19'h0FFFF) ? 16'hFFFF : sum[15:0];
          combo_d = (combo_q == 10'd1023) ? combo_q : combo_q + 10'd1;
          if (combo_d > max_combo_q) max_combo_d = combo_d;
          if (step_q == StepW'(COMBO_STEP - 1)) begin
            step_d = '0;
            if (mult_q < 3'(MAX_MULT)) mult_d = mult_q + 3'd1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          combo_d = '0;
          step_d  = '0;
          mult_d  = 3'd1;
        end
      end

      if (state_q == StPlay) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_hit[i]) begin
            if (pend_q[i] && !ret_oh[i]) begin
              overflow_d = 1'b1;
            end else begin
              pend_d[i]       = 1'b1;
              gr_d[2*i +: 2]  = lane_grade[2*i +: 2];
            end
          end
        end
        if (song_end) state_d = StDrain;
      end else if (state_q == StDrain && pend_d == '0) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      gr_q        <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      mult_q      <= 3'd1;
      step_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      gr_q        <= gr_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      mult_q      <= mult_d;
      step_q      <= step_d;
      overflow_q  <= overflow_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign multiplier = mult_q;
  assign busy       = |pend_q;
  assign overflow   = overflow_q;
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper; inputs driven and outputs
// sampled on the falling edge.
module tb_score_keeper;

  logic        Clk;
  logic        reset;
  logic        start;
  logic        song_end;
  logic [3:0]  lane_hit;
  logic [7:0]  lane_grade;
  logic [15:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic [2:0]  multiplier;
  logic        busy;
  logic        overflow;
  logic        done;

  int total;
  int passed;

  score_keeper dut (
    .Clk        (Clk),
    .reset      (reset),
    .start      (start),
    .song_end   (song_end),
    .lane_hit   (lane_hit),
    .lane_grade (lane_grade),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .multiplier (multiplier),
    .busy       (busy),
    .overflow   (overflow),
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic drive_hit(input logic [3:0] hits, input logic [7:0] grades);
    lane_hit   = hits;
    lane_grade = grades;
    @(negedge Clk);
    lane_hit   = '0;
    lane_grade = '0;
  endtask

  // One lane-1 event followed by the cycle in which it retires.
  task automatic lane1_event(input logic [1:0] g);
    drive_hit(4'b0010, {4'b0000, g, 2'b00});
    @(negedge Clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL %s_drain_timeout busy=%b want 0", name, busy);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (score !== 16'd0) $display("FAIL reset_score got %0d want 0", score); else passed++;
    total++; if (combo !== 10'd0 || max_combo !== 10'd0)
      $display("FAIL reset_combo got %0d/%0d want 0/0", combo, max_combo); else passed++;
    total++; if (multiplier !== 3'd1) $display("FAIL reset_mult got %0d want 1", multiplier); else passed++;
    total++; if ({busy, overflow, done} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {busy, overflow, done}); else passed++;
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_single_hit();
    pulse_start();
    drive_hit(4'b0001, 8'b0000_0011);
    total++; if (busy !== 1'b1 || score !== 16'd0)
      $display("FAIL single_pending busy=%b score=%0d want 1/0", busy, score); else passed++;
    @(negedge Clk);
    total++; if (score !== 16'd512) $display("FAIL single_score got %0d want 512", score); else passed++;
    total++; if (combo !== 10'd1 || multiplier !== 3'd1)
      $display("FAIL single_combo_mult got %0d/%0d want 1/1", combo, multiplier); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_low got %b want 0", busy); else passed++;
  endtask

  task automatic test_mult_step();
    pulse_start();
    for (int k = 1; k <= 11; k++) begin
      lane1_event(2'b11);
      if (k == 10) begin
        total++; if (score !== 16'd5120 || multiplier !== 3'd2)
          $display("FAIL mult_step10 score=%0d mult=%0d want 5120/2", score, multiplier);
        else passed++;
      end
    end
    total++; if (score !== 16'd6144 || combo !== 10'd11)
      $display("FAIL mult_step11 score=%0d combo=%0d want 6144/11", score, combo); else passed++;
  endtask

  task automatic test_miss();
    lane1_event(2'b00);
    total++; if (combo !== 10'd0 || score !== 16'd6144 || multiplier !== 3'd1)
      $display("FAIL miss_clear combo=%0d score=%0d mult=%0d want 0/6144/1", combo, score,
               multiplier);
    else passed++;
    lane1_event(2'b01);
    total++; if (combo !== 10'd1 || max_combo !== 10'd11 || multiplier !== 3'd1)
      $display("FAIL miss_good combo=%0d max=%0d mult=%0d want 1/11/1", combo, max_combo,
               multiplier);
    else passed++;
    total++; if (score !== 16'd6272) $display("FAIL miss_score got %0d want 6272", score);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_all [4];
    logic [15:0] exp_mix [4];
    exp_all = '{16'd256, 16'd512, 16'd768, 16'd1024};
    exp_mix = '{16'd128, 16'd640, 16'd896, 16'd1408};
    pulse_start();
    drive_hit(4'b1111, 8'b10_10_10_10);
    for (int k = 0; k < 4; k++) begin
      total++; if (busy !== 1'b1) $display("FAIL simul_busy%0d got %b want 1", k, busy);
      else passed++;
      @(negedge Clk);
      total++; if (score !== exp_all[k])
        $display("FAIL simul_score%0d got %0d want %0d", k, score, exp_all[k]);
      else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL simul_busy_end got %b want 0", busy); else passed++;
    // Distinct grades make the retirement order observable.
    pulse_start();
    drive_hit(4'b1111, 8'b11_10_11_01);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      total++; if (score !== exp_mix[k])
        $display("FAIL order_score%0d got %0d want %0d", k, score, exp_mix[k]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    lane_hit   = 4'b1111;
    lane_grade = 8'b11_11_11_11;
    @(negedge Clk);
    lane_hit   = 4'b1000;
    @(negedge Clk);
    lane_hit   = '0;
    lane_grade = '0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else passed++;
    wait_idle("ovf");
    total++; if (score !== 16'd2048 || combo !== 10'd4)
      $display("FAIL ovf_score score=%0d combo=%0d want 2048/4", score, combo); else passed++;

    pulse_start();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_cleared got %b want 0", overflow);
    else passed++;
    lane_hit   = 4'b0001;
    lane_grade = 8'b0000_0011;
    @(negedge Clk);
    @(negedge Clk);
    lane_hit   = '0;
    lane_grade = '0;
    wait_idle("rehit");
    total++; if (overflow !== 1'b0 || score !== 16'd1024 || combo !== 10'd2)
      $display("FAIL rehit ovf=%b score=%0d combo=%0d want 0/1024/2", overflow, score, combo);
    else passed++;
  endtask

  task automatic test_saturation();
    pulse_start();
    repeat (46) lane1_event(2'b11);
    total++; if (score !== 16'd63488 || multiplier !== 3'd4)
      $display("FAIL sat_pre score=%0d mult=%0d want 63488/4", score, multiplier); else passed++;
    lane1_event(2'b11);
    total++; if (score !== 16'hFFFF) $display("FAIL sat_clip got %0d want 65535", score);
    else passed++;
    lane1_event(2'b11);
    total++; if (score !== 16'hFFFF || combo !== 10'd48)
      $display("FAIL sat_hold score=%0d combo=%0d want 65535/48", score, combo); else passed++;
  endtask

  task automatic test_song_end();
    pulse_start();
    drive_hit(4'b0011, 8'b0000_1111);
    song_end = 1'b1;
    @(negedge Clk);
    song_end = 1'b0;
    total++; if (done !== 1'b0 || score !== 16'd512)
      $display("FAIL end_drain done=%b score=%0d want 0/512", done, score); else passed++;
    // A hit while draining must be ignored.
    drive_hit(4'b0100, 8'b0011_0000);
    total++; if (done !== 1'b1 || busy !== 1'b0 || score !== 16'd1024)
      $display("FAIL end_done done=%b busy=%b score=%0d want 1/0/1024", done, busy, score);
    else passed++;
    @(negedge Clk);
    total++; if (done !== 1'b1 || score !== 16'd1024)
      $display("FAIL end_hold done=%b score=%0d want 1/1024", done, score); else passed++;
    pulse_start();
    total++; if (done !== 1'b0 || score !== 16'd0 || max_combo !== 10'd0)
      $display("FAIL end_restart done=%b score=%0d max=%0d want 0/0/0", done, score, max_combo);
    else passed++;
  endtask

  task automatic test_reset_mid();
    lane1_event(2'b11);
    drive_hit(4'b1111, 8'b11_11_11_11);
    @(negedge Clk);
    #2 reset = 1'b1;
    #1;
    total++; if (score !== 16'd0 || combo !== 10'd0 || max_combo !== 10'd0)
      $display("FAIL midrst_counts score=%0d combo=%0d max=%0d want 0/0/0", score, combo,
               max_combo);
    else passed++;
    total++; if (multiplier !== 3'd1 || {busy, overflow, done} !== 3'b000)
      $display("FAIL midrst_flags mult=%0d flags=%b want 1/000", multiplier,
               {busy, overflow, done});
    else passed++;
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    total++; if (score !== 16'd0 || busy !== 1'b0)
      $display("FAIL midrst_after score=%0d busy=%b want 0/0", score, busy); else passed++;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    song_end   = 1'b0;
    lane_hit   = '0;
    lane_grade = '0;
    test_reset();
    test_single_hit();
    test_mult_step();
    test_miss();
    test_simultaneous();
    test_overflow();
    test_saturation();
    test_song_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
